// File: rtl/multi_chan_pattern_dut.sv
// Multi-channel pattern generator: NUM_CH counter/LFSR/toggle/hold channels
// presented round-robin, one channel per beat, on a single valid/ready stream.
module multi_chan_pattern_dut #(
  parameter int          NUM_CH = 4,
  parameter int          DATA_W = 32,
  parameter logic [63:0] POLY   = 64'h8020_0003,
  parameter logic [63:0] SEED   = 64'h1,
  localparam int         CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_step,
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic              i_load,
  input  logic [CH_W-1:0]   i_ch_sel,
  input  logic [DATA_W-1:0] i_load_val,
  output logic              o_load_ack,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CH_W-1:0]   o_ch,
  output logic              o_wrap
);

  localparam logic [DATA_W-1:0] POLY_W = POLY[DATA_W-1:0];
  localparam logic [DATA_W-1:0] SEED_W = SEED[DATA_W-1:0];

  logic [DATA_W-1:0] state_q [NUM_CH];
  logic [CH_W-1:0]   ptr_q;
  logic [NUM_CH-1:0] en_q;
  logic              run_q;
  logic              wrap_q;

  logic              accept;
  logic              load_do;
  logic              load_hit_cur;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] sum;
  logic              carry;
  logic [DATA_W-1:0] lfsr_nxt;
  logic [DATA_W-1:0] adv;
  logic [CH_W-1:0]   nxt_ptr;
  logic [CH_W-1:0]   cand;
  logic              found;

  assign o_valid = run_q && en_q[ptr_q];
  assign o_data  = state_q[ptr_q];
  assign o_ch    = ptr_q;
  assign o_wrap  = wrap_q;
  assign accept  = o_valid && i_ready;

  // A stalled beat must stay stable, so a load aimed at it is refused.
  assign o_load_ack   = rst && i_load && !(o_valid && !i_ready && (i_ch_sel == ptr_q));
  assign load_do      = o_load_ack && ({1'b0, i_ch_sel} < (CH_W + 1)'(NUM_CH));
  assign load_hit_cur = load_do && (i_ch_sel == ptr_q);

  always_comb begin
    cur          = state_q[ptr_q];
    {carry, sum} = {1'b0, cur} + {1'b0, i_step};
    lfsr_nxt     = (cur == '0) ? SEED_W : ((cur >> 1) ^ (cur[0] ? POLY_W : '0));
    case (i_mode)
      2'd0:    adv = sum;
      2'd1:    adv = lfsr_nxt;
      2'd2:    adv = ~cur;
      default: adv = cur;
    endcase
  end

  // Next enabled channel strictly after ptr, wrapping; ptr itself if it is the only one.
  always_comb begin
    nxt_ptr = ptr_q;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(ptr_q) + k) % NUM_CH);
      if (!found && en_q[cand]) begin
        nxt_ptr = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= '0;
      ptr_q  <= '0;
      en_q   <= '0;
      run_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      run_q  <= i_run;
      wrap_q <= accept && (i_mode == 2'd0) && carry && !load_hit_cur;
      if (!o_valid || accept) en_q <= i_ch_en;
      if (accept || (!o_valid && !en_q[ptr_q])) ptr_q <= nxt_ptr;
      if (accept) state_q[ptr_q] <= adv;
      if (load_do) state_q[i_ch_sel] <= i_load_val;
    end
  end

endmodule
